// File: rtl/draw_pkg.sv
// Shared command codes, colours, geometry defaults and FSM/region types
// for the puzzle draw engine.
package draw_pkg;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_CLEAR  = 3'd1;
  localparam logic [2:0] CMD_GRID   = 3'd2;
  localparam logic [2:0] CMD_EZ     = 3'd3;
  localparam logic [2:0] CMD_NORMAL = 3'd4;
  localparam logic [2:0] CMD_HARD   = 3'd5;
  localparam logic [2:0] CMD_NUM    = 3'd6;
  localparam logic [2:0] CMD_RSVD   = 3'd7;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] RED    = 3'b100;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_GRID_X0  = 40;
  localparam int DEF_GRID_Y0  = 20;
  localparam int DEF_CELL     = 20;
  localparam int DEF_BANNER_Y0 = 104;
  localparam int BANNER_H     = 8;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  typedef struct packed {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
  } region_t;

  // Blank tile is black; tiles whose low bits are zero (8) would vanish, so show them white.
  function automatic logic [2:0] tile_colour(input logic [3:0] v);
    if (v == 4'd0)             return BLACK;
    else if (v[2:0] == 3'd0)   return WHITE;
    else                       return v[2:0];
  endfunction

endpackage

// File: rtl/draw_engine_rect_scanner.sv
// Raster walker over a rectangle: x/y position plus per-axis cell counters
// and clamped 4x4 row/col indices, stepping one pixel per enabled clock.
module rect_scanner
  import draw_pkg::*;
#(
  parameter int CELL = DEF_CELL
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_start,
  input  logic       i_step,
  input  logic [7:0] i_x0,
  input  logic [6:0] i_y0,
  input  logic [7:0] i_w,
  input  logic [6:0] i_h,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic [1:0] o_col,
  output logic [1:0] o_row,
  output logic       o_on_line,
  output logic       o_last
);

  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CELL - 1);

  logic [7:0]    r_x, r_x0, r_xend;
  logic [6:0]    r_y, r_yend;
  logic [CW-1:0] r_cx, r_cy;
  logic [1:0]    r_col, r_row;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_x0   <= '0;
      r_xend <= '0;
      r_yend <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (i_start) begin
      r_x    <= i_x0;
      r_y    <= i_y0;
      r_x0   <= i_x0;
      r_xend <= i_x0 + i_w - 8'd1;
      r_yend <= i_y0 + i_h - 7'd1;
      r_cx   <= '0;
      r_cy   <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (i_step) begin
      if (r_x == r_xend) begin
        r_x   <= r_x0;
        r_cx  <= '0;
        r_col <= '0;
        if (r_y != r_yend) begin
          r_y <= r_y + 7'd1;
          if (r_cy == CMAX) begin
            r_cy <= '0;
            // closing line sits one past the last cell; keep its index in range
            if (r_row != 2'd3) r_row <= r_row + 2'd1;
          end else begin
            r_cy <= r_cy + 1'b1;
          end
        end
      end else begin
        r_x <= r_x + 8'd1;
        if (r_cx == CMAX) begin
          r_cx <= '0;
          if (r_col != 2'd3) r_col <= r_col + 2'd1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_col     = r_col;
  assign o_row     = r_row;
  assign o_on_line = (r_cx == '0) || (r_cy == '0);
  assign o_last    = (r_x == r_xend) && (r_y == r_yend);

endmodule

// File: rtl/draw_engine.sv
// Command-driven rasteriser for the sliding-puzzle screen: one pixel per clock
// into the VGA write port, one-cycle done when the region is finished.
module draw_engine
  import draw_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int GRID_X0   = DEF_GRID_X0,
  parameter int GRID_Y0   = DEF_GRID_Y0,
  parameter int CELL      = DEF_CELL,
  parameter int BANNER_Y0 = DEF_BANNER_Y0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [63:0] board,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] GRID_SPAN = 8'(4 * CELL + 1);

  state_t      r_state;
  logic [2:0]  r_cmd;
  logic [63:0] r_board;

  logic        w_accept;
  region_t     w_region;
  logic [7:0]  w_sx;
  logic [6:0]  w_sy;
  logic [1:0]  w_col, w_row;
  logic        w_on_line, w_last;
  logic [3:0]  w_tile;

  assign w_accept = (r_state == S_IDLE) && cmd_valid &&
                    (cmd != CMD_NONE) && (cmd != CMD_RSVD);

  always_comb begin
    w_region = '{x0: 8'd0, y0: 7'd0, w: 8'(SCREEN_W), h: 7'(SCREEN_H)};
    case (cmd)
      CMD_GRID, CMD_NUM:
        w_region = '{x0: 8'(GRID_X0), y0: 7'(GRID_Y0), w: GRID_SPAN, h: 7'(GRID_SPAN)};
      CMD_EZ, CMD_NORMAL, CMD_HARD:
        w_region = '{x0: 8'(GRID_X0), y0: 7'(BANNER_Y0), w: GRID_SPAN, h: 7'(BANNER_H)};
      default: ;
    endcase
  end

  rect_scanner #(.CELL(CELL)) u_scan (
    .clk       (clk),
    .resetn    (resetn),
    .i_start   (w_accept),
    .i_step    (r_state == S_SCAN),
    .i_x0      (w_region.x0),
    .i_y0      (w_region.y0),
    .i_w       (w_region.w),
    .i_h       (w_region.h),
    .o_x       (w_sx),
    .o_y       (w_sy),
    .o_col     (w_col),
    .o_row     (w_row),
    .o_on_line (w_on_line),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cmd   <= CMD_NONE;
      r_board <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_SCAN;
          r_cmd   <= cmd;
          r_board <= board;
        end
        S_SCAN:  if (w_last) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_tile = r_board[{w_row, w_col, 2'b00} +: 4];

  always_comb begin
    colour = BLACK;
    plot   = 1'b0;
    if (r_state == S_SCAN) begin
      case (r_cmd)
        CMD_CLEAR:  begin colour = BLACK;  plot = 1'b1; end
        CMD_GRID:   begin colour = WHITE;  plot = w_on_line; end
        CMD_EZ:     begin colour = GREEN;  plot = 1'b1; end
        CMD_NORMAL: begin colour = YELLOW; plot = 1'b1; end
        CMD_HARD:   begin colour = RED;    plot = 1'b1; end
        CMD_NUM:    if (!w_on_line) begin
          colour = tile_colour(w_tile);
          plot   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign x    = w_sx;
  assign y    = w_sy;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_draw_engine.sv
// Directed + randomised bench for draw_engine against a geometric pixel model.
module tb_draw_engine;

  localparam int GX0 = 40, GY0 = 20, CEL = 20, BY0 = 104;

  logic        clk = 1'b0;
  logic        resetn, cmd_valid;
  logic [2:0]  cmd;
  logic [63:0] board;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int     total = 0, passed = 0;
  longint cyc = 0;
  logic [3:0] scr [0:159][0:119];

  draw_engine dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd(cmd), .board(board),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic region(input int c, output int x0, output int y0, output int w, output int h);
    case (c)
      1:       begin x0 = 0;   y0 = 0;   w = 160; h = 120; end
      3, 4, 5: begin x0 = GX0; y0 = BY0; w = 81;  h = 8;   end
      default: begin x0 = GX0; y0 = GY0; w = 81;  h = 81;  end
    endcase
  endtask

  // {plot, colour} expected at (px,py); unplotted pixels encode as 0
  function automatic int model_px(input int c, input logic [63:0] b, input int px, input int py);
    int dx, dy, r, cl;
    bit line;
    logic [3:0] v;
    case (c)
      1: return 8;
      3: return 8 + 2;
      4: return 8 + 6;
      5: return 8 + 4;
      default: begin
        dx = px - GX0; dy = py - GY0;
        line = (dx % CEL == 0) || (dy % CEL == 0);
        if (c == 2) return line ? 15 : 0;
        if (line) return 0;
        r = dy / CEL; cl = dx / CEL;
        v = b[(r * 4 + cl) * 4 +: 4];
        if (v == 0) return 8;
        if (v[2:0] == 0) return 15;
        return 8 + int'(v[2:0]);
      end
    endcase
  endfunction

  // Called right after the accepting edge: walks every pixel, then done, then idle.
  task automatic scan_check(input int c, input logic [63:0] b, input string tag,
                            output int plotted, output longint dcyc);
    int x0, y0, w, h, bad, e, a, k;
    region(c, x0, y0, w, h);
    bad = 0; plotted = 0; k = 0;
    for (int yy = y0; yy < y0 + h; yy++) begin
      for (int xx = x0; xx < x0 + w; xx++) begin
        e = model_px(c, b, xx, yy);
        a = plot ? (8 + int'(colour)) : 0;
        if (int'(x) != xx || int'(y) != yy || a != e || busy !== 1'b1 || done !== 1'b0) begin
          if (bad == 0)
            $display("  %s first bad pixel k=%0d dut(%0d,%0d) pc=%0d model(%0d,%0d) pc=%0d busy=%b done=%b",
                     tag, k, x, y, a, xx, yy, e, busy, done);
          bad++;
        end
        if (x < 160 && y < 120) scr[x][y] = {plot, plot ? colour : 3'b000};
        plotted += int'(plot);
        k++;
        tick();
      end
    end
    chk({tag, " bad pixels"}, bad, 0);
    chk({tag, " done"}, {busy, done}, 2'b11);
    dcyc = cyc;
    tick();
    chk({tag, " idle after"}, {busy, done, plot}, 3'b000);
  endtask

  initial begin
    int p, bad, gap, c;
    longint d1, d2;
    logic [63:0] b;

    resetn = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; board = '0;
    repeat (3) tick();
    chk("rst x", x, 0);
    chk("rst y", y, 0);
    chk("rst colour", colour, 0);
    chk("rst plot", plot, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    resetn = 1'b1;
    tick();

    // GRID
    b = {$urandom, $urandom};
    cmd = 3'd2; board = b; cmd_valid = 1'b1; tick();
    cmd_valid = 1'b0;
    scan_check(2, b, "grid", p, d1);
    chk("grid plotted", p, 785);
    chk("grid first px", scr[40][20], 4'hF);
    chk("grid 41,21 plot", scr[41][21][3], 0);
    chk("grid 60,50 plot", scr[60][50][3], 1);
    chk("grid last px", scr[120][100], 4'hF);

    // NUM, board scrambled after acceptance
    b = {$urandom, $urandom};
    b[3:0] = 4'h0; b[23:20] = 4'h3; b[63:60] = 4'h8;
    cmd = 3'd6; board = b; cmd_valid = 1'b1; tick();
    cmd_valid = 1'b0; board = ~b;
    scan_check(6, b, "num", p, d1);
    chk("num 70,50", scr[70][50], 4'b1011);
    chk("num 110,90", scr[110][90], 4'b1111);
    chk("num blank", scr[50][30], 4'b1000);
    chk("num line plot", scr[60][30][3], 0);

    // HARD, with EZ held during the scan
    cmd = 3'd5; cmd_valid = 1'b1; tick();
    cmd = 3'd3;
    scan_check(5, b, "hard", p, d1);
    chk("hard plotted", p, 648);
    tick();
    cmd_valid = 1'b0;
    scan_check(3, b, "ez after hard", p, d1);
    chk("ez colour", scr[40][104], 4'b1010);

    // codes 7 and 0 ignored
    foreach (scr[i]) ;
    for (int i = 0; i < 2; i++) begin
      cmd = (i == 0) ? 3'd7 : 3'd0; cmd_valid = 1'b1; bad = 0;
      repeat (10) begin
        tick();
        if (busy || done || plot) bad++;
      end
      chk(i == 0 ? "cmd7 ignored" : "cmd0 ignored", bad, 0);
    end
    cmd_valid = 1'b0;

    // CLEAR interrupted by reset at pixel 5000
    cmd = 3'd1; cmd_valid = 1'b1; tick();
    cmd_valid = 1'b0;
    repeat (5000) tick();
    chk("clear px5000", {x, y}, {8'd40, 7'd31});
    resetn = 1'b0; tick();
    chk("mid rst outs", {x, y, colour, plot, busy, done}, 21'd0);
    resetn = 1'b1;
    bad = 0;
    repeat (3) begin tick(); if (done || busy) bad++; end
    chk("no done after rst", bad, 0);
    cmd = 3'd1; cmd_valid = 1'b1; tick();
    cmd_valid = 1'b0;
    scan_check(1, b, "clear", p, d1);
    chk("clear plotted", p, 19200);
    chk("clear 0,0", scr[0][0], 4'b1000);

    // back-to-back EZ with valid held
    cmd = 3'd3; cmd_valid = 1'b1; tick();
    scan_check(3, b, "ez1", p, d1);
    tick();
    cmd_valid = 1'b0;
    scan_check(3, b, "ez2", p, d2);
    chk("ez done spacing", d2 - d1, 650);

    // randomised commands
    repeat (4) begin
      c = int'($urandom_range(2, 6));
      b = {$urandom, $urandom};
      gap = int'($urandom_range(0, 5));
      repeat (gap) tick();
      cmd = 3'(c); board = b; cmd_valid = 1'b1; tick();
      cmd_valid = 1'b0; board = {$urandom, $urandom};
      scan_check(c, b, "rand", p, d1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
